memwb_skid_stage: RTL and testbench

//  Parametrised MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/memwb_skid_stage.sv | 148 ++++++++++++++
 tb/tb_memwb_skid_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake and a two-entry skid buffer.
// Carries write-back control, load data, ALU result and rd to WB; counts stalled cycles.
module memwb_skid_stage #(
    parameter int unsigned WB_W      = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned RW_BIT    = 1,
    parameter int unsigned ZERO_KILL = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   in_wb_i,
    input  logic [DATA_W-1:0] in_rdata_i,
    input  logic [DATA_W-1:0] in_alu_i,
    input  logic [REG_W-1:0]  in_rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   out_wb_o,
    output logic [DATA_W-1:0] out_rdata_o,
    output logic [DATA_W-1:0] out_alu_o,
    output logic [REG_W-1:0]  out_rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [WB_W-1:0]   main_wb_q, skid_wb_q;
    logic [DATA_W-1:0] main_rdata_q, skid_rdata_q;
    logic [DATA_W-1:0] main_alu_q, skid_alu_q;
    logic [REG_W-1:0]  main_rd_q, skid_rd_q;

    logic              acc, dlv;
    logic              load_main_in, load_main_skid, load_skid_in;
    logic [WB_W-1:0]   wb_load;

    assign acc = in_valid_i & in_ready_q;
    assign dlv = main_valid_q & out_ready_i;

    // A write to x0 is architecturally dead, so drop its RegWrite at capture time.
    always_comb begin
        wb_load = in_wb_i;
        if (ZERO_KILL != 0 && in_rd_i == '0) begin
            wb_load[RW_BIT] = 1'b0;
        end
    end

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low while skid is full, so no new beat can arrive here.
            if (dlv) begin
                load_main_skid = 1'b1;
                main_valid_d   = 1'b1;
                skid_valid_d   = 1'b0;
            end
        end else if (!main_valid_q || dlv) begin
            if (acc) begin
                load_main_in = 1'b1;
                main_valid_d = 1'b1;
            end else if (dlv) begin
                main_valid_d = 1'b0;
            end
        end else if (acc) begin
            load_skid_in = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready_i && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_wb_q    <= '0;
            main_rdata_q <= '0;
            main_alu_q   <= '0;
            main_rd_q    <= '0;
        end else if (load_main_skid) begin
            main_wb_q    <= skid_wb_q;
            main_rdata_q <= skid_rdata_q;
            main_alu_q   <= skid_alu_q;
            main_rd_q    <= skid_rd_q;
        end else if (load_main_in) begin
            main_wb_q    <= wb_load;
            main_rdata_q <= in_rdata_i;
            main_alu_q   <= in_alu_i;
            main_rd_q    <= in_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_wb_q    <= '0;
            skid_rdata_q <= '0;
            skid_alu_q   <= '0;
            skid_rd_q    <= '0;
        end else if (load_skid_in) begin
            skid_wb_q    <= wb_load;
            skid_rdata_q <= in_rdata_i;
            skid_alu_q   <= in_alu_i;
            skid_rd_q    <= in_rd_i;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_wb_o    = main_valid_q ? main_wb_q : '0;
    assign out_rdata_o = main_rdata_q;
    assign out_alu_o   = main_alu_q;
    assign out_rd_o    = main_rd_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Randomised scoreboard bench for memwb_skid_stage: a FIFO-of-beats model predicts
// every output, a 2-bit-counter instance exercises saturation.
module tb_memwb_skid_stage;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [1:0]  in_wb;
    logic [31:0] in_rdata, in_alu;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [1:0]  out_wb, out_wb2;
    logic [31:0] out_rdata, out_alu, out_rdata2, out_alu2;
    logic [4:0]  out_rd, out_rd2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    int sc16 = 0;
    int sc2 = 0;

    always #5 clk = ~clk;

    memwb_skid_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_wb_i(in_wb), .in_rdata_i(in_rdata), .in_alu_i(in_alu), .in_rd_i(in_rd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_wb_o(out_wb), .out_rdata_o(out_rdata), .out_alu_o(out_alu), .out_rd_o(out_rd),
        .stall_cnt_o(stall_cnt)
    );

    memwb_skid_stage #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_wb_i(in_wb), .in_rdata_i(in_rdata), .in_alu_i(in_alu), .in_rd_i(in_rd),
        .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .out_wb_o(out_wb2), .out_rdata_o(out_rdata2), .out_alu_o(out_alu2), .out_rd_o(out_rd2),
        .stall_cnt_o(stall_cnt2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: stage is a FIFO of at most two beats; writes to x0 lose RegWrite (bit 1).
    initial begin
        bit acc, dlv;
        beat_t b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                sc16 = 0;
                sc2  = 0;
            end else begin
                dlv = (exp_q.size() > 0) && out_ready;
                acc = in_valid && (exp_q.size() < 2);
                if (exp_q.size() > 0 && !out_ready) begin
                    if (sc16 < 65535) sc16++;
                    if (sc2 < 3) sc2++;
                end
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (dlv) void'(exp_q.pop_front());
                    if (acc) begin
                        b.wb    = (in_rd == 0) ? (in_wb & 2'b01) : in_wb;
                        b.rdata = in_rdata;
                        b.alu   = in_alu;
                        b.rd    = in_rd;
                        exp_q.push_back(b);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(sc16));
        chk("stall_cnt_sat", 64'(stall_cnt2), 64'(sc2));
        if (exp_q.size() > 0) begin
            chk("out_wb", 64'(out_wb), 64'(exp_q[0].wb));
            chk("out_rdata", 64'(out_rdata), 64'(exp_q[0].rdata));
            chk("out_alu", 64'(out_alu), 64'(exp_q[0].alu));
            chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
        end else begin
            chk("out_wb_idle", 64'(out_wb), 64'd0);
        end
    end

    task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [4:0] rd, input logic ordy, input logic fl);
        in_valid  = v;
        in_wb     = wb;
        in_rdata  = $urandom;
        in_alu    = alu;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_wb = '0; in_rdata = '0; in_alu = '0; in_rd = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming
        for (int i = 1; i <= 3; i++) drive(1'b1, 2'b10, 32'(i), 5'd3, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);

        // Stall into skid, then drain
        drive(1'b1, 2'b10, 32'hA, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'hB, 5'd4, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);

        // Zero kill
        drive(1'b1, 2'b11, 32'h10, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 2'b11, 32'h11, 5'd5, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);

        // Flush with both entries full and a beat offered
        drive(1'b1, 2'b10, 32'h20, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h21, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h22, 5'd6, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_wb", 64'(out_wb), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        repeat (2) drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);

        // Async reset between edges with two beats held
        drive(1'b1, 2'b10, 32'h30, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h31, 5'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_wb", 64'(out_wb), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Saturation of the 2-bit counter
        drive(1'b1, 2'b10, 32'h40, 5'd8, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("sat_cnt2", 64'(stall_cnt2), 64'd3);
        chk("sat_cnt16", 64'(stall_cnt), 64'd5);
        drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("sat_hold", 64'(stall_cnt2), 64'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        repeat (4) drive(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
